l15_mem_responder: RTL and testbench

L15_MEM_RESPONDER -- requirements
Module: l15_mem_responder

---
 rtl/l15_mem_responder_pkg.sv | 24 ++
 rtl/wt_cache_pkg.sv | 72 +++++++
 rtl/l15_resp_mem.sv | 34 +++
 rtl/l15_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_l15_mem_responder.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/l15_mem_responder_pkg.sv
// Responder-local types: FSM state, backing-store line and byte-enable types,
// and the store byte-enable helper shared by the top and the memory.
package l15_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } resp_state_e;

  localparam int LineBytes = 16;

  typedef logic [8*LineBytes-1:0] line_t;
  typedef logic [LineBytes-1:0]   line_be_t;

  // 2^size bytes starting at offset; bytes past the end of the line fall off.
  function automatic line_be_t store_be(input logic [1:0] size, input logic [3:0] offset);
    logic [31:0] mask;
    mask = (32'd1 << (32'd1 << size)) - 32'd1;
    mask = mask << offset;
    return mask[LineBytes-1:0];
  endfunction

endpackage

// File: rtl/wt_cache_pkg.sv
// Request/return encodings and packed L1.5 interface structs shared with the
// write-through cache. Only the encodings this slice touches are listed.
package wt_cache_pkg;

  localparam int L15_TID_WIDTH     = 2;
  localparam int L15_TLB_CSM_WIDTH = 33;

  typedef enum logic [4:0] {
    L15_LOAD_RQ   = 5'b00000,
    L15_STORE_RQ  = 5'b00001,
    L15_CAS1_RQ   = 5'b00010,
    L15_CAS2_RQ   = 5'b00011,
    L15_ATOMIC_RQ = 5'b00110,
    L15_IMISS_RQ  = 5'b10000
  } l15_reqtypes_t;

  typedef enum logic [3:0] {
    L15_LOAD_RET   = 4'b0000,
    L15_IFILL_RET  = 4'b0001,
    L15_EVICT_REQ  = 4'b0011,
    L15_ST_ACK     = 4'b0100,
    L15_INT_RET    = 4'b0111,
    L15_ATOMIC_RET = 4'b1110
  } l15_rtrntypes_t;

  typedef struct packed {
    logic                         l15_val;
    logic                         l15_req_ack;
    l15_reqtypes_t                l15_rqtype;
    logic                         l15_nc;
    logic [2:0]                   l15_size;
    logic [L15_TID_WIDTH-1:0]     l15_threadid;
    logic                         l15_prefetch;
    logic                         l15_invalidate_cacheline;
    logic                         l15_blockstore;
    logic                         l15_blockinitstore;
    logic [1:0]                   l15_l1rplway;
    logic [63:0]                  l15_address;
    logic [63:0]                  l15_data;
    logic [63:0]                  l15_data_next_entry;
    logic [L15_TLB_CSM_WIDTH-1:0] l15_csm_data;
    logic [3:0]                   l15_amo_op;
  } l15_req_t;

  typedef struct packed {
    logic                     l15_ack;
    logic                     l15_header_ack;
    logic                     l15_val;
    l15_rtrntypes_t           l15_returntype;
    logic                     l15_l2miss;
    logic [1:0]               l15_error;
    logic                     l15_noncacheable;
    logic                     l15_atomic;
    logic [L15_TID_WIDTH-1:0] l15_threadid;
    logic                     l15_prefetch;
    logic                     l15_f4b;
    logic [63:0]              l15_data_0;
    logic [63:0]              l15_data_1;
    logic [63:0]              l15_data_2;
    logic [63:0]              l15_data_3;
    logic                     l15_inval_icache_all_way;
    logic                     l15_inval_dcache_all_way;
    logic [15:4]              l15_inval_address_15_4;
    logic                     l15_cross_invalidate;
    logic [1:0]               l15_cross_invalidate_way;
    logic                     l15_inval_dcache_inval;
    logic                     l15_inval_icache_inval;
    logic [1:0]               l15_inval_way;
    logic                     l15_blockinitstore;
  } l15_rtrn_t;

endpackage

// File: rtl/l15_resp_mem.sv
// Backing store: 128-bit lines, one asynchronous read port, one byte-enabled
// write port. Contents are never reset; preload_line seeds it in simulation.
module l15_resp_mem
  import l15_mem_responder_pkg::*;
#(
  parameter int unsigned Lines = 1024
) (
  input  logic                     clk_i,
  input  logic [$clog2(Lines)-1:0] rd_idx_i,
  output line_t                    rd_line_o,
  input  logic                     we_i,
  input  logic [$clog2(Lines)-1:0] wr_idx_i,
  input  line_be_t                 be_i,
  input  line_t                    wdata_i
);

  line_t mem_q [Lines];

  assign rd_line_o = mem_q[rd_idx_i];

  // Plain always: preload_line also writes this array.
  always @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < LineBytes; b++) begin
        if (be_i[b]) mem_q[wr_idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  task preload_line(input logic [$clog2(Lines)-1:0] idx, input line_t line);
    mem_q[idx] <= line;
  endtask

endmodule

// File: rtl/l15_mem_responder.sv
// Single-outstanding L1.5 memory responder: acks a request in IDLE, answers
// RespLatency cycles later from a 16 B-line backing store.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | ready; a valid request is acked and captured this cycle
//   ST_WAIT | latency down-counter running, no ack
//   ST_RESP | one-cycle return pulse; store write lands on this edge
module l15_mem_responder
  import wt_cache_pkg::*;
  import l15_mem_responder_pkg::*;
#(
  parameter int unsigned MemLines    = 1024,
  parameter int unsigned RespLatency = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  l15_req_t  l15_req_i,
  output l15_rtrn_t l15_rtrn_o
);

  localparam int unsigned     IdxW    = $clog2(MemLines);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);
  localparam logic [7:0]      CntLoad = 8'(RespLatency - 1);

  resp_state_e              state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [4:0]               rqtype_q, rqtype_d;
  logic                     nc_q, nc_d;
  logic [2:0]               size_q, size_d;
  logic [L15_TID_WIDTH-1:0] tid_q, tid_d;
  logic [39:0]              addr_q, addr_d;
  logic [63:0]              data_q, data_d;
  line_t                    even_q, even_d;

  logic            accept;
  logic            is_load, is_imiss, is_store;
  logic [IdxW-1:0] req_idx, cap_idx, rd_idx;
  line_t           rd_line, wr_data;
  line_be_t        wr_be;
  logic            wr_en;
  logic            unused_req;

  assign accept   = (state_q == ST_IDLE) && l15_req_i.l15_val;
  assign req_idx  = l15_req_i.l15_address[4 +: IdxW];
  assign cap_idx  = addr_q[4 +: IdxW];
  assign is_load  = (rqtype_q == L15_LOAD_RQ);
  assign is_imiss = (rqtype_q == L15_IMISS_RQ);
  assign is_store = (rqtype_q == L15_STORE_RQ);

  // The even line of an ifill pair is fetched while accepting, the odd one in RESP.
  always_comb begin
    rd_idx = cap_idx;
    if (state_q == ST_IDLE) rd_idx = req_idx & ~IdxOne;
    else if (is_imiss)      rd_idx = cap_idx | IdxOne;
  end

  assign wr_be   = store_be(size_q[1:0], addr_q[3:0]);
  assign wr_data = line_t'(data_q) << {addr_q[3:0], 3'b000};

  assign unused_req = ^{l15_req_i, addr_q, size_q};

  l15_resp_mem #(
    .Lines (MemLines)
  ) u_mem (
    .clk_i     (clk_i),
    .rd_idx_i  (rd_idx),
    .rd_line_o (rd_line),
    .we_i      (wr_en),
    .wr_idx_i  (cap_idx),
    .be_i      (wr_be),
    .wdata_i   (wr_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rqtype_q <= '0;
      nc_q     <= 1'b0;
      size_q   <= '0;
      tid_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      even_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rqtype_q <= rqtype_d;
      nc_q     <= nc_d;
      size_q   <= size_d;
      tid_q    <= tid_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      even_q   <= even_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rqtype_d = rqtype_q;
    nc_d     = nc_q;
    size_d   = size_q;
    tid_d    = tid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    even_d   = even_q;
    case (state_q)
      ST_IDLE: begin
        if (l15_req_i.l15_val) begin
          rqtype_d = l15_req_i.l15_rqtype;
          nc_d     = l15_req_i.l15_nc;
          size_d   = l15_req_i.l15_size;
          tid_d    = l15_req_i.l15_threadid;
          addr_d   = l15_req_i.l15_address[39:0];
          data_d   = l15_req_i.l15_data;
          even_d   = rd_line;
          cnt_d    = CntLoad;
          state_d  = (RespLatency == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 8'd1) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    l15_rtrn_o                = '0;
    wr_en                     = 1'b0;
    l15_rtrn_o.l15_ack        = accept & rst_ni;
    l15_rtrn_o.l15_header_ack = accept & rst_ni;
    if (state_q == ST_RESP) begin
      l15_rtrn_o.l15_val      = 1'b1;
      l15_rtrn_o.l15_threadid = tid_q;
      if (is_load) begin
        l15_rtrn_o.l15_returntype   = L15_LOAD_RET;
        l15_rtrn_o.l15_noncacheable = nc_q;
        l15_rtrn_o.l15_data_0       = rd_line[63:0];
        l15_rtrn_o.l15_data_1       = rd_line[127:64];
      end else if (is_imiss) begin
        l15_rtrn_o.l15_returntype = L15_IFILL_RET;
        l15_rtrn_o.l15_data_0     = even_q[63:0];
        l15_rtrn_o.l15_data_1     = even_q[127:64];
        l15_rtrn_o.l15_data_2     = rd_line[63:0];
        l15_rtrn_o.l15_data_3     = rd_line[127:64];
      end else if (is_store) begin
        l15_rtrn_o.l15_returntype = L15_ST_ACK;
        wr_en                     = 1'b1;
      end else begin
        l15_rtrn_o.l15_returntype = L15_LOAD_RET;
        l15_rtrn_o.l15_error      = 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_l15_mem_responder.sv
// Directed bench for l15_mem_responder: default instance plus a minimal
// instance (2 lines, latency 1) for the boundary configuration.
module tb_l15_mem_responder;
  import wt_cache_pkg::*;

  localparam logic [127:0] L2 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] L3 = 128'h30313233_34353637_38393A3B_3C3D3E3F;
  localparam logic [127:0] L4 = 128'h40414243_44454647_48494A4B_4C4D4E4F;
  localparam logic [127:0] L5 = 128'h50515253_54555657_58595A5B_5C5D5E5F;

  logic      clk_i = 1'b0;
  logic      rst_ni;
  l15_req_t  req, req1;
  l15_rtrn_t rtrn, rtrn1, rsp;
  int        lat;
  int        n_cmp = 0;
  int        n_err = 0;
  int        n_ack, n_val;
  int        t_ack [3];

  always #5 clk_i = ~clk_i;

  l15_mem_responder #(.MemLines(1024), .RespLatency(4)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .l15_req_i  (req),
    .l15_rtrn_o (rtrn)
  );

  l15_mem_responder #(.MemLines(2), .RespLatency(1)) dut_min (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .l15_req_i  (req1),
    .l15_rtrn_o (rtrn1)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called one step after a rising edge with the DUT idle; returns the response and its latency.
  task automatic xact(input logic [4:0] rqt, input logic nc, input logic [2:0] size,
                      input logic [1:0] tid, input logic [39:0] addr, input logic [63:0] data,
                      output l15_rtrn_t r, output int l);
    req                = '0;
    req.l15_val        = 1'b1;
    req.l15_rqtype     = l15_reqtypes_t'(rqt);
    req.l15_nc         = nc;
    req.l15_size       = size;
    req.l15_threadid   = tid;
    req.l15_address    = {24'h0, addr};
    req.l15_data       = data;
    @(negedge clk_i);
    chk("ack", {rtrn.l15_ack, rtrn.l15_header_ack}, 2'b11);
    @(posedge clk_i); #1;
    req.l15_val = 1'b0;
    r = '0;
    l = 0;
    for (int k = 1; k <= 40 && l == 0; k++) begin
      @(negedge clk_i);
      if (rtrn.l15_val) begin
        r = rtrn;
        l = k;
      end
    end
    @(negedge clk_i);
    chk("val_once", rtrn.l15_val, 1'b0);
    @(posedge clk_i); #1;
  endtask

  task automatic xact_min(input logic [4:0] rqt, input logic [2:0] size, input logic [39:0] addr,
                          input logic [63:0] data, output l15_rtrn_t r);
    req1              = '0;
    req1.l15_val      = 1'b1;
    req1.l15_rqtype   = l15_reqtypes_t'(rqt);
    req1.l15_size     = size;
    req1.l15_threadid = 2'd1;
    req1.l15_address  = {24'h0, addr};
    req1.l15_data     = data;
    @(negedge clk_i);
    chk("min_ack", rtrn1.l15_ack, 1'b1);
    @(posedge clk_i); #1;
    req1.l15_val = 1'b0;
    @(negedge clk_i);
    r = rtrn1;
    chk("min_val", rtrn1.l15_val, 1'b1);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected end before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req         = '0;
    req1        = '0;
    rst_ni      = 1'b0;
    req.l15_val = 1'b1;
    dut.u_mem.preload_line(10'd2, L2);
    dut.u_mem.preload_line(10'd3, L3);
    dut.u_mem.preload_line(10'd4, L4);
    dut.u_mem.preload_line(10'd5, L5);
    #23;
    chk("rst_rtrn_zero", |rtrn, 1'b0);
    req.l15_val = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("idle_rtrn_zero", |rtrn, 1'b0);
    @(posedge clk_i); #1;

    // Load of line 2
    xact(5'b00000, 1'b0, 3'd3, 2'd2, 40'h20, 64'h0, rsp, lat);
    chk("ld_lat", lat, 4);
    chk("ld_rtype", rsp.l15_returntype, 4'b0000);
    chk("ld_d0", rsp.l15_data_0, 64'h8899AABB_CCDDEEFF);
    chk("ld_d1", rsp.l15_data_1, 64'h00112233_44556677);
    chk("ld_d23", {rsp.l15_data_2, rsp.l15_data_3}, 128'h0);
    chk("ld_tid", rsp.l15_threadid, 2'd2);
    chk("ld_err_nc", {rsp.l15_error, rsp.l15_noncacheable}, 3'b000);

    xact(5'b00000, 1'b1, 3'd3, 2'd1, 40'h28, 64'h0, rsp, lat);
    chk("ldnc_nc", rsp.l15_noncacheable, 1'b1);
    chk("ldnc_d0", rsp.l15_data_0, 64'h8899AABB_CCDDEEFF);
    chk("ldnc_d1", rsp.l15_data_1, 64'h00112233_44556677);

    // Instruction fills return the aligned pair of lines 4/5
    xact(5'b10000, 1'b0, 3'd3, 2'd3, 40'h48, 64'h0, rsp, lat);
    chk("if_lat", lat, 4);
    chk("if_rtype", rsp.l15_returntype, 4'b0001);
    chk("if_d0", rsp.l15_data_0, 64'h48494A4B_4C4D4E4F);
    chk("if_d1", rsp.l15_data_1, 64'h40414243_44454647);
    chk("if_d2", rsp.l15_data_2, 64'h58595A5B_5C5D5E5F);
    chk("if_d3", rsp.l15_data_3, 64'h50515253_54555657);
    chk("if_tid", rsp.l15_threadid, 2'd3);

    xact(5'b10000, 1'b0, 3'd3, 2'd0, 40'h58, 64'h0, rsp, lat);
    chk("if58_d0", rsp.l15_data_0, 64'h48494A4B_4C4D4E4F);
    chk("if58_d2", rsp.l15_data_2, 64'h58595A5B_5C5D5E5F);

    // Byte store, then read back
    xact(5'b00001, 1'b0, 3'd0, 2'd1, 40'h23, 64'hDEADBEEF_CAFE12A5, rsp, lat);
    chk("st_rtype", rsp.l15_returntype, 4'b0100);
    chk("st_tid", rsp.l15_threadid, 2'd1);
    chk("st_lat", lat, 4);
    xact(5'b00000, 1'b0, 3'd3, 2'd0, 40'h20, 64'h0, rsp, lat);
    chk("stld_d0", rsp.l15_data_0, 64'h8899AABB_A5DDEEFF);
    chk("stld_d1", rsp.l15_data_1, 64'h00112233_44556677);

    // 8-byte store at offset 12 keeps only the four in-line bytes
    xact(5'b00001, 1'b0, 3'd3, 2'd0, 40'h3C, 64'h11223344_55667788, rsp, lat);
    chk("stx_rtype", rsp.l15_returntype, 4'b0100);
    xact(5'b00000, 1'b0, 3'd3, 2'd0, 40'h30, 64'h0, rsp, lat);
    chk("stx_d0", rsp.l15_data_0, 64'h38393A3B_3C3D3E3F);
    chk("stx_d1", rsp.l15_data_1, 64'h55667788_34353637);

    // 4-byte store straddling the 8-byte halves of line 5
    xact(5'b00001, 1'b0, 3'd2, 2'd0, 40'h56, 64'hFFFFFFFF_A1B2C3D4, rsp, lat);
    xact(5'b10000, 1'b0, 3'd3, 2'd0, 40'h40, 64'h0, rsp, lat);
    chk("st4_l4_d0", rsp.l15_data_0, 64'h48494A4B_4C4D4E4F);
    chk("st4_l4_d1", rsp.l15_data_1, 64'h40414243_44454647);
    chk("st4_d2", rsp.l15_data_2, 64'hC3D45A5B_5C5D5E5F);
    chk("st4_d3", rsp.l15_data_3, 64'h50515253_5455A1B2);

    xact(5'b00000, 1'b0, 3'd3, 2'd0, 40'hAB_0000_4020, 64'h0, rsp, lat);
    chk("alias_d0", rsp.l15_data_0, 64'h8899AABB_A5DDEEFF);

    // Unsupported request type
    xact(5'b00110, 1'b0, 3'd3, 2'd2, 40'h20, 64'hFFFFFFFF_FFFFFFFF, rsp, lat);
    chk("bad_rtype", rsp.l15_returntype, 4'b0000);
    chk("bad_err", rsp.l15_error, 2'b11);
    chk("bad_d01", {rsp.l15_data_1, rsp.l15_data_0}, 128'h0);
    chk("bad_d23", {rsp.l15_data_3, rsp.l15_data_2}, 128'h0);
    chk("bad_tid", rsp.l15_threadid, 2'd2);
    xact(5'b00000, 1'b0, 3'd3, 2'd0, 40'h20, 64'h0, rsp, lat);
    chk("bad_mem_d0", rsp.l15_data_0, 64'h8899AABB_A5DDEEFF);

    // Request held valid across three loads
    req             = '0;
    req.l15_val     = 1'b1;
    req.l15_address = 64'h20;
    n_ack = 0;
    n_val = 0;
    t_ack = '{0, 0, 0};
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      if (rtrn.l15_ack) begin
        if (n_ack < 3) t_ack[n_ack] = c;
        n_ack++;
      end
      if (rtrn.l15_val) n_val++;
      @(posedge clk_i); #1;
      if (n_ack >= 3) req.l15_val = 1'b0;
    end
    chk("held_acks", n_ack, 3);
    chk("held_gap1", t_ack[1] - t_ack[0], 5);
    chk("held_gap2", t_ack[2] - t_ack[1], 5);
    chk("held_vals", n_val, 3);

    // Reset during WAIT of a store aborts it
    req             = '0;
    req.l15_val     = 1'b1;
    req.l15_rqtype  = L15_STORE_RQ;
    req.l15_size    = 3'd3;
    req.l15_address = 64'h20;
    req.l15_data    = 64'h0BAD0BAD_0BAD0BAD;
    @(negedge clk_i);
    chk("rw_ack", rtrn.l15_ack, 1'b1);
    @(posedge clk_i); #1;
    req.l15_val = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("rw_rtrn_zero", |rtrn, 1'b0);
    #2;
    rst_ni = 1'b1;
    n_val = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (rtrn.l15_val) n_val++;
    end
    chk("rw_no_val", n_val, 0);
    @(posedge clk_i); #1;
    xact(5'b00000, 1'b0, 3'd3, 2'd1, 40'h20, 64'h0, rsp, lat);
    chk("rw_lat", lat, 4);
    chk("rw_d0", rsp.l15_data_0, 64'h8899AABB_A5DDEEFF);
    chk("rw_d1", rsp.l15_data_1, 64'h00112233_44556677);

    // Latency-1, two-line instance
    xact_min(5'b00001, 3'd3, 40'h0, 64'h01234567_89ABCDEF, rsp);
    chk("min_st_rtype", rsp.l15_returntype, 4'b0100);
    xact_min(5'b00000, 3'd3, 40'h20, 64'h0, rsp);
    chk("min_ld_rtype", rsp.l15_returntype, 4'b0000);
    chk("min_ld_d0", rsp.l15_data_0, 64'h01234567_89ABCDEF);
    @(negedge clk_i);
    chk("min_val_once", rtrn1.l15_val, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
